enc_prio_stream: RTL and testbench
==================================

ENC_PRIO_STREAM -- requirements
Module: enc_prio_stream

Interface
REQ-001 Parameter N_IN, default 8, SHALL set the number of one-hot request lines; legal range 2..64.
REQ-002 Parameter OUT_W, default $clog2(N_IN), SHALL set the encoded code width; it SHALL NOT be overridden independently of N_IN.
REQ-003 Parameter MSB_FIRST, default 1, SHALL select priority: 1 = highest set index wins, 0 = lowest set index wins.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 in_valid  input  1  SHALL indicate that enc_y is valid.
REQ-007 in_ready  output  1  SHALL indicate that the block can accept enc_y this cycle.
REQ-008 enc_y  input  N_IN  SHALL carry the request vector; bit i is request line i.
REQ-009 out_valid  output  1  SHALL indicate that the head output entry is valid.
REQ-010 out_ready  input  1  SHALL indicate that the consumer accepts the head entry.
REQ-011 out_a  output  OUT_W  SHALL carry the encoded index of the winning request.
REQ-012 out_zero  output  1  SHALL indicate that the accepted vector had no bit set.
REQ-013 out_multi  output  1  SHALL indicate that the accepted vector had more than one bit set.
REQ-014 err_clr  input  1  SHALL synchronously clear err_cnt.
REQ-015 err_cnt  output  8  SHALL hold a saturating count of accepted multi-hot vectors.

Function
REQ-016 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-017 A pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-018 Encoding SHALL be computed combinationally from enc_y at push time; the result {out_a, out_zero, out_multi} SHALL be stored in a 2-entry FIFO.
REQ-019 Encoding result: out_a = index of the winning bit per MSB_FIRST; when no bit is set, out_a=0 and out_zero=1.
REQ-020 out_multi SHALL be 1 iff popcount(enc_y) >= 2, independent of MSB_FIRST.
REQ-021 Latency: an entry pushed at edge k SHALL be visible on out_valid/out_a after edge k when the FIFO was empty; no combinational path from enc_y to out_*.
REQ-022 FIFO occupancy count SHALL range 0..2; in_ready SHALL be 1 iff count<2, registered-derived, with no combinational dependence on out_ready.
REQ-023 out_valid SHALL be 1 iff count>0; out_a/out_zero/out_multi SHALL reflect the oldest entry.
REQ-024 Simultaneous push and pop with count=1 SHALL leave count=1, with the new entry at the head on the next cycle.
REQ-025 Simultaneous push and pop with count=0 is impossible (out_valid=0); push only, count becomes 1.
REQ-026 With count=2, in_ready=0; a pop SHALL reduce count to 1 and raise in_ready on the next cycle.
REQ-027 Order SHALL be strictly FIFO; no entry is dropped or duplicated.
REQ-028 out_* data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 err_cnt SHALL increment by 1 on each push with out_multi=1, saturating at 255 (no wrap).
REQ-030 If err_clr=1 and a multi-hot push occur on the same edge, err_cnt SHALL become 0 (clear wins).
REQ-031 enc_y SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-032 While rst_n=0: count=0, out_valid=0, in_ready=0, out_a=0, out_zero=0, out_multi=0, err_cnt=0, asynchronously.
REQ-033 in_ready SHALL go to 1 on the first rising edge after rst_n deasserts.
REQ-034 Reset asserted mid-operation SHALL discard all FIFO entries immediately; no partial pop is visible.

Verification
REQ-035 N_IN=8, MSB_FIRST=1: push enc_y=8'b0010_0000, out_ready=1 -> next cycle out_valid=1, out_a=5, out_zero=0, out_multi=0.
REQ-036 N_IN=8: push 8'b1000_0010 with MSB_FIRST=1 -> out_a=7, out_multi=1, err_cnt=1; with MSB_FIRST=0 -> out_a=1.
REQ-037 out_ready=0, push 0x01, 0x04, then attempt 0x10 -> in_ready=0 after 2 pushes; third vector not accepted; pops return out_a=0, then out_a=2, in order.
REQ-038 Push enc_y=0 -> out_a=0, out_zero=1, out_multi=0, err_cnt unchanged.
REQ-039 Push 300 multi-hot vectors -> err_cnt=255; then err_clr=1 concurrent with a multi-hot push -> err_cnt=0.
REQ-040 N_IN=16, MSB_FIRST=1: push 16'h8000 -> out_a=4'd15; assert rst_n=0 with count=2 -> out_valid=0 immediately, count=0 after release.

Source files
------------

// File: rtl/enc_prio_stream_if.sv
// Stream bundle for the priority encoder: request vector in, encoded result out.
interface enc_prio_stream_if #(
  parameter int N_IN  = 8,
  parameter int OUT_W = $clog2(N_IN)
);
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  enc_y;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_a;
  logic             out_zero;
  logic             out_multi;

  modport master (
    output in_valid, enc_y, out_ready,
    input  in_ready, out_valid, out_a, out_zero, out_multi
  );

  modport slave (
    input  in_valid, enc_y, out_ready,
    output in_ready, out_valid, out_a, out_zero, out_multi
  );
endinterface

// File: rtl/enc_prio_stream.sv
// Priority encoder for one-hot request vectors with a 2-entry result FIFO
// and a saturating counter of multi-hot vectors seen at the input.
module enc_prio_stream #(
  parameter int N_IN      = 8,
  parameter int OUT_W     = $clog2(N_IN),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  enc_prio_stream_if.slave        strm,
  input  logic                    err_clr,
  output logic [7:0]              err_cnt
);

  typedef struct packed {
    logic [OUT_W-1:0] a;
    logic             zero;
    logic             multi;
  } enc_t;

  // Ascending scan: MSB_FIRST keeps overwriting so the highest index wins,
  // otherwise only the first set bit is taken.
  function automatic enc_t encode(input logic [N_IN-1:0] v);
    enc_t r;
    r.a     = '0;
    r.zero  = 1'b1;
    r.multi = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      r.multi = r.multi | (v[i] & ~r.zero);
      r.a     = (v[i] && (MSB_FIRST || r.zero)) ? OUT_W'(i) : r.a;
      r.zero  = r.zero & ~v[i];
    end
    return r;
  endfunction

  enc_t       enc_s;
  enc_t       head_r;
  enc_t       tail_r;
  logic [1:0] count_r;
  logic [1:0] count_nxt_s;
  logic       in_ready_r;
  logic       out_valid_r;
  logic [7:0] err_cnt_r;
  logic       push_s;
  logic       pop_s;

  assign strm.in_ready  = in_ready_r;
  assign strm.out_valid = out_valid_r;
  assign strm.out_a     = head_r.a;
  assign strm.out_zero  = head_r.zero;
  assign strm.out_multi = head_r.multi;
  assign err_cnt        = err_cnt_r;

  // Handshake qualification and next occupancy.
  always_comb begin
    enc_s       = encode(strm.enc_y);
    push_s      = strm.in_valid & in_ready_r;
    pop_s       = out_valid_r & strm.out_ready;
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage: head_r drives the outputs directly, tail_r holds the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= 2'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      err_cnt_r   <= 8'd0;
    end else begin
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != 2'd0);
      in_ready_r  <= (count_nxt_s != 2'd2);
      case (count_r)
        2'd0: begin
          if (push_s) head_r <= enc_s;
        end
        2'd1: begin
          if (push_s && !pop_s) tail_r <= enc_s;
          else if (push_s)      head_r <= enc_s;
        end
        2'd2: begin
          if (pop_s) head_r <= tail_r;
        end
        default: begin
          head_r <= head_r;
        end
      endcase
      // Clear takes precedence over a coincident multi-hot push.
      if (err_clr)
        err_cnt_r <= 8'd0;
      else if (push_s && enc_s.multi && (err_cnt_r != 8'hFF))
        err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

endmodule

// File: tb/tb_enc_prio_stream.sv
// Directed scoreboard bench: three encoder instances (8/MSB, 8/LSB, 16/MSB).
module tb_enc_prio_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       err_clr = 1'b0;
  logic [7:0] err_cnt0, err_cnt1, err_cnt2;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [5:0] q0[$], q1[$], q2[$];
  logic [5:0] e0, e1, e2;

  enc_prio_stream_if #(.N_IN(8))  if0 ();
  enc_prio_stream_if #(.N_IN(8))  if1 ();
  enc_prio_stream_if #(.N_IN(16)) if2 ();

  enc_prio_stream #(.N_IN(8), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .strm(if0), .err_clr(err_clr), .err_cnt(err_cnt0));
  enc_prio_stream #(.N_IN(8), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .strm(if1), .err_clr(err_clr), .err_cnt(err_cnt1));
  enc_prio_stream #(.N_IN(16), .MSB_FIRST(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .strm(if2), .err_clr(err_clr), .err_cnt(err_cnt2));

  always #5 clk = ~clk;

  function automatic logic [5:0] ex(input int a, input logic z, input logic m);
    return {4'(a), z, m};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: compare the head entry whenever a pop is about to happen.
  always @(negedge clk) begin
    if (rst_n && if0.out_valid && if0.out_ready) begin
      if (q0.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut0_unexpected: got a=%0d expected no entry", if0.out_a);
      end else begin
        e0 = q0.pop_front();
        check("dut0_out", {10'd0, 1'b0, if0.out_a, if0.out_zero, if0.out_multi}, {10'd0, e0});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut1_unexpected: got a=%0d expected no entry", if1.out_a);
      end else begin
        e1 = q1.pop_front();
        check("dut1_out", {10'd0, 1'b0, if1.out_a, if1.out_zero, if1.out_multi}, {10'd0, e1});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if2.out_valid && if2.out_ready) begin
      if (q2.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut2_unexpected: got a=%0d expected no entry", if2.out_a);
      end else begin
        e2 = q2.pop_front();
        check("dut2_out", {10'd0, if2.out_a, if2.out_zero, if2.out_multi}, {10'd0, e2});
      end
    end
  end

  function automatic logic rdy(input int d);
    case (d)
      0:       return if0.in_ready;
      1:       return if1.in_ready;
      default: return if2.in_ready;
    endcase
  endfunction

  // Called at posedge+1; presents the vector for exactly one accepting edge.
  task automatic push(input int d, input logic [15:0] v, input logic [5:0] e);
    int n = 0;
    while (!rdy(d) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: dut%0d in_ready stayed 0, required 1", d);
    end else begin
      case (d)
        0:       begin if0.in_valid = 1'b1; if0.enc_y = v[7:0]; q0.push_back(e); end
        1:       begin if1.in_valid = 1'b1; if1.enc_y = v[7:0]; q1.push_back(e); end
        default: begin if2.in_valid = 1'b1; if2.enc_y = v;      q2.push_back(e); end
      endcase
      @(posedge clk); #1;
      if0.in_valid = 1'b0;
      if1.in_valid = 1'b0;
      if2.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d entries left, required 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  initial begin
    if0.in_valid = 1'b0; if0.enc_y = '0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.enc_y = '0; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.enc_y = '0; if2.out_ready = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready",  {15'd0, if0.in_ready},  16'd0);
    check("rst_out_valid", {15'd0, if0.out_valid}, 16'd0);
    check("rst_out_a",     {13'd0, if0.out_a},     16'd0);
    check("rst_out_zero",  {15'd0, if0.out_zero},  16'd0);
    check("rst_out_multi", {15'd0, if0.out_multi}, 16'd0);
    check("rst_err_cnt",   {8'd0, err_cnt0},       16'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", {15'd0, if0.in_ready}, 16'd1);

    // Basic encodes, one-cycle latency, zero vector
    if0.out_ready = 1'b1;
    push(0, 16'h0020, ex(5, 1'b0, 1'b0));
    check("latency_out_valid", {15'd0, if0.out_valid}, 16'd1);
    push(0, 16'h0082, ex(7, 1'b0, 1'b1));
    check("err_cnt_multi", {8'd0, err_cnt0}, 16'd1);
    push(0, 16'h0000, ex(0, 1'b1, 1'b0));
    check("err_cnt_zero_vec", {8'd0, err_cnt0}, 16'd1);
    drain();

    // Back-pressure: fill both entries, third vector must be refused
    if0.out_ready = 1'b0;
    push(0, 16'h0001, ex(0, 1'b0, 1'b0));
    push(0, 16'h0004, ex(2, 1'b0, 1'b0));
    check("full_in_ready", {15'd0, if0.in_ready}, 16'd0);
    if0.in_valid = 1'b1; if0.enc_y = 8'h10;
    repeat (3) @(posedge clk);
    #1;
    check("full_in_ready_hold", {15'd0, if0.in_ready}, 16'd0);
    check("full_head_stable",   {13'd0, if0.out_a},    16'd0);
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    drain();

    // Streaming with simultaneous push/pop
    push(0, 16'h0003, ex(1, 1'b0, 1'b1));
    push(0, 16'h0040, ex(6, 1'b0, 1'b0));
    push(0, 16'h00FF, ex(7, 1'b0, 1'b1));
    check("err_cnt_stream", {8'd0, err_cnt0}, 16'd3);
    drain();

    // Lowest-index priority instance
    if1.out_ready = 1'b1;
    push(1, 16'h0082, ex(1, 1'b0, 1'b1));
    push(1, 16'h0028, ex(3, 1'b0, 1'b1));
    push(1, 16'h0080, ex(7, 1'b0, 1'b0));
    push(1, 16'h0000, ex(0, 1'b1, 1'b0));
    drain();
    check("lsb_err_cnt", {8'd0, err_cnt1}, 16'd2);

    // Saturation then clear racing a multi-hot push
    repeat (300) push(0, 16'h0081, ex(7, 1'b0, 1'b1));
    check("err_cnt_sat", {8'd0, err_cnt0}, 16'd255);
    err_clr = 1'b1;
    push(0, 16'h00C0, ex(7, 1'b0, 1'b1));
    err_clr = 1'b0;
    check("err_clr_wins", {8'd0, err_cnt0}, 16'd0);
    drain();

    // 16-bit instance and reset with two entries held
    if2.out_ready = 1'b1;
    push(2, 16'h8000, ex(15, 1'b0, 1'b0));
    push(2, 16'h0101, ex(8, 1'b0, 1'b1));
    drain();
    if2.out_ready = 1'b0;
    push(2, 16'h0010, ex(4, 1'b0, 1'b0));
    push(2, 16'h0003, ex(1, 1'b0, 1'b1));
    check("w16_full_in_ready",  {15'd0, if2.in_ready},  16'd0);
    check("w16_full_out_valid", {15'd0, if2.out_valid}, 16'd1);
    #2 rst_n = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    #1;
    check("midrst_out_valid", {15'd0, if2.out_valid}, 16'd0);
    check("midrst_out_a",     {12'd0, if2.out_a},     16'd0);
    check("midrst_in_ready",  {15'd0, if2.in_ready},  16'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready",  {15'd0, if2.in_ready},  16'd1);
    check("postrst_out_valid", {15'd0, if2.out_valid}, 16'd0);
    if2.out_ready = 1'b1;
    push(2, 16'h0004, ex(2, 1'b0, 1'b0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
